// File: rtl/axis_conv_out_serializer_pkg.sv
// Shared types and sizing for the convolution-output serializer.
// All other files import this package so the widths stay in one place.
package conv_out_pkg;

  localparam int CONV_UNITS        = 8;
  localparam int DATA_WIDTH        = 16;
  localparam int TUSER_WIDTH       = 4;
  localparam int FIFO_DEPTH        = 4;
  localparam int ALMOST_FULL_LEVEL = 3;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(CONV_UNITS);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Packed so a whole beat moves through the FIFO memory as one vector.
  typedef struct packed {
    word_t [CONV_UNITS-1:0]  data;
    logic                    last;
    logic [TUSER_WIDTH-1:0]  user;
  } beat_t;

endpackage

// File: rtl/axis_conv_out_serializer_if.sv
// Serial AXI-Stream word channel leaving the serializer.
// Handshake: a word transfers on a clock edge where tvalid and tready are both 1
// (and the clock enable is 1); tvalid and its payload hold until that transfer.
interface axis_conv_out_serializer_if import conv_out_pkg::*; ();

  logic                   tvalid;
  logic                   tready;
  word_t                  tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);

endinterface

// File: rtl/axis_conv_out_serializer_fifo.sv
// Synchronous beat FIFO. A push into a full FIFO is accepted only when a pop
// happens at the same edge; otherwise it is ignored and the caller flags it.
module axis_beat_fifo import conv_out_pkg::*; (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           aclken,
  input  logic           push,
  input  logic           pop,
  input  beat_t          wdata,
  output beat_t          rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  beat_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = aclken && pop && !empty;
  assign do_push = aclken && push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axis_conv_out_serializer.sv
// Captures non-stallable CONV_UNITS-wide engine beats into a beat FIFO and
// re-emits them one word at a time on an AXI-Stream master with tready.
module axis_conv_out_serializer import conv_out_pkg::*; (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       aclken,
  input  logic                       s_valid,
  input  word_t                      s_data [CONV_UNITS-1:0],
  input  logic                       s_last,
  input  logic [TUSER_WIDTH-1:0]     s_user,
  axis_conv_out_serializer_if.master m_axis,
  output logic                       almost_full,
  output logic                       overflow
);

  beat_t            in_beat;
  beat_t            head;
  beat_t            stage;
  logic             stage_valid;
  logic [IDX_W-1:0] idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_count;
  logic [PTR_W:0]   count_next;
  logic             handshake;
  logic             last_word;
  logic             stage_load;
  logic             push_ok;
  logic             drop;

  always_comb begin
    in_beat      = '0;
    in_beat.last = s_last;
    in_beat.user = s_user;
    for (int i = 0; i < CONV_UNITS; i++) in_beat.data[i] = s_data[i];
  end

  assign handshake  = aclken && stage_valid && m_axis.tready;
  assign last_word  = (idx == IDX_W'(CONV_UNITS-1));
  // Reload while the final word leaves so consecutive beats have no bubble.
  assign stage_load = aclken && !fifo_empty && (!stage_valid || (handshake && last_word));
  assign push_ok    = aclken && s_valid && (!fifo_full || stage_load);
  assign drop       = aclken && s_valid && fifo_full && !stage_load;
  assign count_next = fifo_count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(stage_load);

  axis_beat_fifo u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .aclken  (aclken),
    .push    (s_valid),
    .pop     (stage_load),
    .wdata   (in_beat),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stage       <= '0;
      stage_valid <= 1'b0;
      idx         <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else if (aclken) begin
      if (stage_load) begin
        stage       <= head;
        stage_valid <= 1'b1;
        idx         <= '0;
      end else if (handshake) begin
        if (last_word) begin
          stage_valid <= 1'b0;
          idx         <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      almost_full <= (count_next >= (PTR_W+1)'(ALMOST_FULL_LEVEL));
    end
  end

  assign m_axis.tvalid = stage_valid;
  assign m_axis.tdata  = stage.data[idx];
  assign m_axis.tlast  = stage.last && last_word;
  assign m_axis.tuser  = stage.user;

endmodule

// File: tb/tb_axis_conv_out_serializer.sv
// Directed bench for axis_conv_out_serializer: drives engine beats and tready on
// the falling edge and checks every serial word against an expected queue.
module tb_axis_conv_out_serializer;
  import conv_out_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic aclken = 1'b0;
  always #5 clk = ~clk;

  logic                   s_valid = 1'b0;
  word_t                  s_data [CONV_UNITS-1:0];
  logic                   s_last = 1'b0;
  logic [TUSER_WIDTH-1:0] s_user = '0;
  logic                   almost_full;
  logic                   overflow;

  axis_conv_out_serializer_if m_axis();

  axis_conv_out_serializer dut (
    .aclk        (clk),
    .aresetn     (aresetn),
    .aclken      (aclken),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_user      (s_user),
    .m_axis      (m_axis),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_count = 0;
  int          cyc = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_beat(input logic [15:0] base, input logic lst, input logic [3:0] usr);
    for (int j = 0; j < CONV_UNITS; j++)
      exp_q.push_back({11'd0, (j == CONV_UNITS-1) ? lst : 1'b0, usr, 16'(base + 16'(j) + 16'd1)});
  endtask

  // One cycle: drive inputs at the falling edge, then judge what the coming edge transfers.
  task automatic cycle(input logic sv, input logic [15:0] base, input logic lst,
                       input logic [3:0] usr, input logic rdy, input logic en);
    logic [31:0] cur;
    logic        hs;
    @(negedge clk);
    s_valid = sv;
    s_last  = sv ? lst : 1'b0;
    s_user  = sv ? usr : 4'h0;
    for (int j = 0; j < CONV_UNITS; j++) s_data[j] = sv ? 16'(base + 16'(j) + 16'd1) : 16'h0;
    m_axis.tready = rdy;
    aclken = en;
    cur = {11'd0, m_axis.tlast, m_axis.tuser, m_axis.tdata};
    hs  = en && m_axis.tvalid && rdy;
    if (held_v) check("hold_stable", cur, held_val);
    if (hs) begin
      hs_count++;
      if (hs_count == 1) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) check("extra_word", cur, 32'hFFFF_FFFF);
      else check("word", cur, exp_q.pop_front());
    end
    held_v   = m_axis.tvalid && !hs;
    held_val = cur;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 4'h0, rdy, 1'b1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    aresetn = 1'b0;
    s_valid = 1'b0;
    m_axis.tready = 1'b0;
    exp_q.delete();
    held_v = 1'b0;
    hs_count = 0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < CONV_UNITS; j++) s_data[j] = '0;
    m_axis.tready = 1'b0;
    reset_dut();
    aclken = 1'b1;

    // reset state
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis.tdata), 32'd0);
    check("rst_tlast", 32'(m_axis.tlast), 32'd0);
    check("rst_tuser", 32'(m_axis.tuser), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // single beat, latency and order
    hs_count = 0;
    expect_beat(16'h0000, 1'b1, 4'h5);
    cycle(1'b1, 16'h0000, 1'b1, 4'h5, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("lat_edge_k", 32'(m_axis.tvalid), 32'd0);
    idle(1, 1'b1);
    check("lat_edge_k1", 32'(m_axis.tvalid), 32'd1);
    idle(9, 1'b1);
    check("single_hs", 32'(hs_count), 32'd8);
    check("single_left", 32'(exp_q.size()), 32'd0);

    // backpressure, tready toggling
    hs_count = 0;
    expect_beat(16'h0010, 1'b1, 4'h3);
    cycle(1'b1, 16'h0010, 1'b1, 4'h3, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) idle(1, 1'(i % 2));
    check("bp_hs", 32'(hs_count), 32'd8);
    check("bp_left", 32'(exp_q.size()), 32'd0);

    // back-to-back beats with no bubble
    hs_count = 0;
    expect_beat(16'h0020, 1'b0, 4'h1);
    expect_beat(16'h0030, 1'b1, 4'h2);
    cycle(1'b1, 16'h0020, 1'b0, 4'h1, 1'b1, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 16'h0030, 1'b1, 4'h2, 1'b1, 1'b1);
    idle(20, 1'b1);
    check("b2b_hs", 32'(hs_count), 32'd16);
    check("b2b_span", 32'(last_hs_cyc - first_hs_cyc), 32'd15);
    check("b2b_left", 32'(exp_q.size()), 32'd0);

    // overflow: six beats against a stalled sink
    hs_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_beat(16'(16'h0040 + 16'(i) * 16'h10), 1'(i % 2), 4'(i));
      cycle(1'b1, 16'(16'h0040 + 16'(i) * 16'h10), 1'(i % 2), 4'(i), 1'b0, 1'b1);
    end
    idle(2, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_almost_full", 32'(almost_full), 32'd1);
    idle(45, 1'b1);
    check("ovf_drain_hs", 32'(hs_count), 32'd40);
    check("ovf_drain_left", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_af_clear", 32'(almost_full), 32'd0);

    // full FIFO with a push on the last-word pop edge
    reset_dut();
    check("rst2_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      expect_beat(16'(16'h0100 + 16'(i) * 16'h10), 1'b1, 4'(i + 8));
      cycle(1'b1, 16'(16'h0100 + 16'(i) * 16'h10), 1'b1, 4'(i + 8), 1'b0, 1'b1);
    end
    idle(2, 1'b0);
    check("full_af", 32'(almost_full), 32'd1);
    check("full_no_ovf", 32'(overflow), 32'd0);
    expect_beat(16'h0200, 1'b0, 4'hC);
    for (int j = 0; j < CONV_UNITS; j++)
      cycle(1'(j == CONV_UNITS-1), 16'h0200, 1'b0, 4'hC, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("full_pop_no_ovf", 32'(overflow), 32'd0);
    idle(45, 1'b1);
    check("full_drain_hs", 32'(hs_count), 32'd48);
    check("full_drain_left", 32'(exp_q.size()), 32'd0);
    check("full_end_ovf", 32'(overflow), 32'd0);

    // clock enable freeze mid-beat
    hs_count = 0;
    expect_beat(16'h0300, 1'b1, 4'h6);
    cycle(1'b1, 16'h0300, 1'b1, 4'h6, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("ce_before", 32'(hs_count), 32'd3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    check("ce_frozen", 32'(hs_count), 32'd3);
    check("ce_word_idx3", 32'(m_axis.tdata), 32'h0304);
    idle(2, 1'b1);
    check("ce_after", 32'(hs_count), 32'd5);

    // asynchronous reset mid-beat
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("arst_tdata", 32'(m_axis.tdata), 32'd0);
    check("arst_tuser", 32'(m_axis.tuser), 32'd0);
    check("arst_tlast", 32'(m_axis.tlast), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_almost_full", 32'(almost_full), 32'd0);
    reset_dut();
    expect_beat(16'h0400, 1'b0, 4'h7);
    cycle(1'b1, 16'h0400, 1'b0, 4'h7, 1'b1, 1'b1);
    idle(11, 1'b1);
    check("restart_hs", 32'(hs_count), 32'd8);
    check("restart_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_conv_out_serializer.md
Name: axis_conv_out_serializer

Overview:
Receiver for the convolution engine's master output. The engine emits CONV_UNITS parallel results per beat (valid/data/last/user) and has no backpressure. This block captures each beat into a small beat FIFO and re-emits the results one word at a time on a standard AXI-Stream master with tready, ready for a DMA or width converter. It also reports fill level and any overflow caused by the non-stallable producer.

Parameters:
- CONV_UNITS, 8, results per input beat (words serialised per beat).
- DATA_WIDTH, 16, bits per result word.
- TUSER_WIDTH, 4, sideband width, passed through per beat.
- FIFO_DEPTH, 4, beat FIFO depth; power of 2, at least 2.
- ALMOST_FULL_LEVEL, 3, occupancy in beats at or above which almost_full asserts.

Ports:
- aclk, input, 1, clock.
- aresetn, input, 1, asynchronous active-low reset.
- aclken, input, 1, clock enable; when low, all state freezes.
- s_valid, input, 1, engine output beat valid; no ready is returned.
- s_data, input, DATA_WIDTH x CONV_UNITS (unpacked array [CONV_UNITS-1:0]), engine results.
- s_last, input, 1, last beat of the engine's output frame.
- s_user, input, TUSER_WIDTH, engine sideband.
- m_axis_tvalid, output, 1, serial word valid.
- m_axis_tready, input, 1, downstream ready.
- m_axis_tdata, output, DATA_WIDTH, current word.
- m_axis_tlast, output, 1, final word of a beat captured with s_last=1.
- m_axis_tuser, output, TUSER_WIDTH, s_user of the beat being serialised.
- almost_full, output, 1, FIFO occupancy >= ALMOST_FULL_LEVEL.
- overflow, output, 1, sticky: a beat was dropped.

Behaviour:
- Reset (aresetn=0, asynchronous): FIFO empty, word index 0, output stage empty. All outputs are 0, including overflow and almost_full.
- aclken=0: no push, pop, or index change. Outputs hold their values. A tready seen during such a cycle is not a handshake.
- Push: s_valid=1 with aclken=1 writes {s_data, s_last, s_user} into the FIFO at the edge.
- Full push: if the FIFO is full and no pop occurs at the same edge, the beat is dropped and overflow goes to 1 until reset. If the FIFO is full and a pop occurs at the same edge, the push is accepted.
- Output stage: holds one beat plus a word index in 0..CONV_UNITS-1.
  - It loads the FIFO head when empty.
  - It also loads at the edge where the word at index CONV_UNITS-1 handshakes, so there is no bubble between consecutive beats.
- Word order:
  - m_axis_tdata = beat[index], emitted from index 0 up to CONV_UNITS-1.
  - Each handshake (tvalid and tready, aclken=1) increments the index.
  - The index wraps to 0 after CONV_UNITS-1.
- m_axis_tlast = stored last AND index==CONV_UNITS-1. m_axis_tuser is constant across all words of a beat.
- Latency: a beat pushed into an empty block at edge k raises m_axis_tvalid after edge k+1 with word 0.
- Throughput: one word per cycle while tready=1. Sustainable input rate is one beat per CONV_UNITS cycles; faster input consumes FIFO slots.
- AXIS rules: once m_axis_tvalid=1, it and tdata/tlast/tuser stay stable until the handshake. tvalid never depends combinationally on tready.
- m_axis_tvalid = output stage holds a beat.
- Occupancy counts FIFO entries only, excluding the output stage; almost_full is registered from it.
- Mid-operation reset discards all FIFO and output-stage contents.

Decomposition:
- Package conv_out_pkg holds:
  - word_t (logic [DATA_WIDTH-1:0]);
  - beat_t struct {word_t data[CONV_UNITS]; logic last; logic [TUSER_WIDTH-1:0] user};
  - FIFO pointer-width localparam derived via $clog2(FIFO_DEPTH).
- One sub-module, axis_beat_fifo: synchronous FIFO of beat_t with push, pop, full, empty and count, using the same aclk/aresetn/aclken.
- The serialiser (output stage, index counter, overflow logic) lives in the top module.

Test Plan:
- Single beat: push data 1..8, user=4'h5, last=1, tready=1 → tvalid from edge k+1, words 1,2,…,8 on 8 consecutive cycles, tuser=5 throughout, tlast only on the word 8 cycle.
- Backpressure: push a beat, then toggle tready 1,0,1,0… → exactly 8 handshakes, data held stable during tready=0, tlast only on the last one.
- Back-to-back beats: push A (last=0) then B (last=1) every 8 cycles, tready=1 → 16 consecutive words with no gap; tlast only after B's 8th word.
- Overflow: tready=0, push 6 beats with FIFO_DEPTH=4 → output stage holds beat 1, FIFO holds beats 2-5, beat 6 dropped; overflow=1 and almost_full=1; draining yields exactly beats 1-5; overflow stays 1.
- Full with simultaneous pop: hold the FIFO full, push on the same edge as the last-word handshake → no drop, overflow stays 0.
- Clock enable and reset: aclken=0 for 5 cycles mid-beat with tready=1 → index unchanged. Then assert aresetn=0 mid-beat → all outputs 0 immediately; the next push restarts at word 0.
